locker_access_controller: RTL and testbench

Sequencing controller for the automated delivery locker bank. It arbitrates between courier deposits and customer retrievals and allocates the lowest free locker. It stores a per-locker 4-bit retrieval PIN, drives one-hot door-open pulses of fixed length, and enforces a failed-attempt lockout. It sits between the keypad/PIN comparator front end and the locker door drivers and LED display.

---
 rtl/locker_access_controller_if.sv | 39 +++
 rtl/locker_access_controller.sv | 197 +++++++++++++++++++
 tb/tb_locker_access_controller.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/locker_access_controller_if.sv
// Request/status bus between the keypad/PIN front end (master) and the
// locker access controller (slave).
interface locker_access_controller_if #(
    parameter int NUM_LOCKERS = 8,
    parameter int LW          = $clog2(NUM_LOCKERS)
);
    logic                   reset_lockers;
    logic                   dep_req;
    logic                   package_present;
    logic                   ret_req;
    logic [LW-1:0]          ret_locker;
    logic [3:0]             pin_in;
    logic                   pin_valid;
    logic                   auth_ok;

    logic [NUM_LOCKERS-1:0] locker_doors;
    logic [LW-1:0]          assigned_locker;
    logic                   assign_valid;
    logic [NUM_LOCKERS-1:0] occupied;
    logic                   full;
    logic                   busy;
    logic                   dep_reject;
    logic                   auth_fail;
    logic                   locked_out;

    modport master (
        output reset_lockers, dep_req, package_present, ret_req, ret_locker,
               pin_in, pin_valid, auth_ok,
        input  locker_doors, assigned_locker, assign_valid, occupied, full,
               busy, dep_reject, auth_fail, locked_out
    );

    modport slave (
        input  reset_lockers, dep_req, package_present, ret_req, ret_locker,
               pin_in, pin_valid, auth_ok,
        output locker_doors, assigned_locker, assign_valid, occupied, full,
               busy, dep_reject, auth_fail, locked_out
    );
endinterface

// File: rtl/locker_access_controller.sv
// Locker bank sequencer: allocates the lowest free locker to deposits, checks
// retrieval PINs, pulses door outputs and enforces a failed-attempt lockout.
module locker_access_controller #(
    parameter int NUM_LOCKERS      = 8,
    parameter int DOOR_OPEN_CYCLES = 16,
    parameter int MAX_ATTEMPTS     = 3,
    parameter int LOCKOUT_CYCLES   = 64,
    parameter int AUTH_TIMEOUT     = 255
) (
    input logic                       clk,
    input logic                       reset,
    locker_access_controller_if.slave bus
);
    localparam int LW   = $clog2(NUM_LOCKERS);
    localparam int TMAX = (DOOR_OPEN_CYCLES > LOCKOUT_CYCLES)
                        ? ((DOOR_OPEN_CYCLES > AUTH_TIMEOUT) ? DOOR_OPEN_CYCLES : AUTH_TIMEOUT)
                        : ((LOCKOUT_CYCLES > AUTH_TIMEOUT) ? LOCKOUT_CYCLES : AUTH_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_ATTEMPTS + 1);

    // Timer reload values: a state holding N cycles counts N-1 down to 0.
    localparam logic [TW-1:0] T_OPEN = TW'(DOOR_OPEN_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_AUTH = TW'(AUTH_TIMEOUT - 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_ATTEMPTS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DEP_AUTH, S_DEP_PIN, S_RET_AUTH, S_OPEN, S_LOCKOUT
    } state_e;

    state_e                 state_q;
    logic [TW-1:0]          timer_q;
    logic [LW-1:0]          alloc_q;
    logic [LW-1:0]          alloc_d;
    logic [LW-1:0]          ret_q;
    logic [NUM_LOCKERS-1:0] doors_q;
    logic [NUM_LOCKERS-1:0] occupied_q;
    logic [FW-1:0]          fail_cnt_q;
    logic [FW-1:0]          fail_cnt_d;
    logic                   assign_valid_q;
    logic                   dep_reject_q;
    logic                   auth_fail_q;
    logic                   full;
    logic                   timer_done;
    logic [3:0]             pin_mem [NUM_LOCKERS];

    function automatic logic [NUM_LOCKERS-1:0] onehot(input logic [LW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Lowest-index free locker; only consulted when the bank is not full.
    always_comb begin
        // NOTE: default assigned before the loop so no path leaves alloc_d unassigned (no latch)
        alloc_d = '0;
        for (int i = NUM_LOCKERS - 1; i >= 0; i--) begin
            if (!occupied_q[i]) alloc_d = LW'(i);
        end
    end

    assign full       = &occupied_q;
    assign timer_done = (timer_q == '0);
    assign fail_cnt_d = fail_cnt_q + FW'(1);

    // NOTE: sequential state uses non-blocking assignments only; a later assignment in the block overrides an earlier one
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            alloc_q        <= '0;
            ret_q          <= '0;
            doors_q        <= '0;
            occupied_q     <= '0;
            fail_cnt_q     <= '0;
            assign_valid_q <= 1'b0;
            dep_reject_q   <= 1'b0;
            auth_fail_q    <= 1'b0;
        end else if (bus.reset_lockers && state_q != S_LOCKOUT) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            doors_q        <= '0;
            occupied_q     <= '0;
            assign_valid_q <= 1'b0;
            dep_reject_q   <= 1'b0;
            auth_fail_q    <= 1'b0;
        end else begin
            assign_valid_q <= 1'b0;
            dep_reject_q   <= 1'b0;
            auth_fail_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.dep_req && bus.package_present) begin
                        if (full) begin
                            dep_reject_q <= 1'b1;
                        end else begin
                            alloc_q <= alloc_d;
                            timer_q <= T_AUTH;
                            state_q <= S_DEP_AUTH;
                        end
                    end else if (bus.ret_req && occupied_q[bus.ret_locker]) begin
                        ret_q   <= bus.ret_locker;
                        timer_q <= T_AUTH;
                        state_q <= S_RET_AUTH;
                    end
                end

                S_DEP_AUTH: begin
                    if (bus.pin_valid && bus.auth_ok) begin
                        fail_cnt_q <= '0;
                        timer_q    <= T_AUTH;
                        state_q    <= S_DEP_PIN;
                    end else if (bus.pin_valid) begin
                        auth_fail_q <= 1'b1;
                        fail_cnt_q  <= fail_cnt_d;
                        timer_q     <= T_LOCK;
                        state_q     <= (fail_cnt_q == FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
                    end else if (timer_done) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                S_DEP_PIN: begin
                    if (bus.pin_valid) begin
                        occupied_q[alloc_q] <= 1'b1;
                        assign_valid_q      <= 1'b1;
                        doors_q             <= onehot(alloc_q);
                        timer_q             <= T_OPEN;
                        state_q             <= S_OPEN;
                    end else if (timer_done) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                S_RET_AUTH: begin
                    if (bus.pin_valid && bus.pin_in == pin_mem[ret_q]) begin
                        occupied_q[ret_q] <= 1'b0;
                        fail_cnt_q        <= '0;
                        doors_q           <= onehot(ret_q);
                        timer_q           <= T_OPEN;
                        state_q           <= S_OPEN;
                    end else if (bus.pin_valid) begin
                        auth_fail_q <= 1'b1;
                        fail_cnt_q  <= fail_cnt_d;
                        timer_q     <= T_LOCK;
                        state_q     <= (fail_cnt_q == FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
                    end else if (timer_done) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                S_OPEN: begin
                    if (timer_done) begin
                        doors_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                S_LOCKOUT: begin
                    // Bulk free still applies here, but the lockout runs to completion.
                    if (bus.reset_lockers) occupied_q <= '0;
                    if (timer_done) begin
                        fail_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: PIN storage has no reset; a slot is only read while its occupied bit is set
    always_ff @(posedge clk) begin
        if (state_q == S_DEP_PIN && bus.pin_valid) pin_mem[alloc_q] <= bus.pin_in;
    end

    assign bus.locker_doors    = doors_q;
    assign bus.assigned_locker = alloc_q;
    assign bus.assign_valid    = assign_valid_q;
    assign bus.occupied        = occupied_q;
    assign bus.full            = full;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.dep_reject      = dep_reject_q;
    assign bus.auth_fail       = auth_fail_q;
    assign bus.locked_out      = (state_q == S_LOCKOUT);
endmodule

// File: tb/tb_locker_access_controller.sv
// Bench for locker_access_controller: a deposit/retrieval vector table plus
// hand-written corner sequences, with a scoreboard of expected output events.
module tb_locker_access_controller;
    typedef enum int {OP_DEP, OP_RET} op_e;
    typedef enum int {EV_NONE, EV_OPEN, EV_FAIL, EV_REJECT} ev_e;

    typedef struct {
        op_e        op;
        logic [2:0] locker;
        logic [3:0] pin;
        logic       auth_ok;
        logic [2:0] exp_locker;
    } vec_t;

    typedef struct {
        ev_e        kind;
        logic [7:0] doors;
        logic [7:0] occ;
        logic       av;
        logic [2:0] locker;
        logic       locked;
        int         len;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    locker_access_controller_if #(.NUM_LOCKERS(8)) bus ();

    locker_access_controller #(
        .NUM_LOCKERS(8), .DOOR_OPEN_CYCLES(16), .MAX_ATTEMPTS(3),
        .LOCKOUT_CYCLES(64), .AUTH_TIMEOUT(255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    ev_t        sb[$];
    logic [7:0] occ_m = '0;
    logic [3:0] pin_m [8];
    int         fail_m = 0;
    vec_t       vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ev_t mk_ev(input ev_e k, input logic [7:0] d, input logic [7:0] o,
                                  input logic av, input logic [2:0] lk, input logic locked,
                                  input int len);
        ev_t e;
        e.kind = k; e.doors = d; e.occ = o; e.av = av;
        e.locker = lk; e.locked = locked; e.len = len;
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 400) begin
            tick();
            n++;
        end
        check("wait_idle", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic do_dep(input logic [3:0] pin, input logic auth, input logic [2:0] exp_lk);
        logic       rej;
        logic [7:0] oh;
        rej = &occ_m;
        if (rej) sb.push_back(mk_ev(EV_REJECT, 8'h00, occ_m, 1'b0, 3'd0, 1'b0, 0));
        bus.dep_req = 1'b1; bus.package_present = 1'b1;
        tick();
        bus.dep_req = 1'b0; bus.package_present = 1'b0;
        if (rej) begin
            check("reject_busy", {31'd0, bus.busy}, 32'd0);
            return;
        end
        check("dep_busy", {31'd0, bus.busy}, 32'd1);
        check("dep_assigned", {29'd0, bus.assigned_locker}, {29'd0, exp_lk});
        if (!auth) begin
            fail_m++;
            sb.push_back(mk_ev(EV_FAIL, 8'h00, occ_m, 1'b0, 3'd0, fail_m == 3, 0));
        end
        bus.auth_ok = auth; bus.pin_valid = 1'b1;
        tick();
        bus.auth_ok = 1'b0; bus.pin_valid = 1'b0;
        if (!auth) begin
            check("dep_fail_busy", {31'd0, bus.busy}, {31'd0, fail_m == 3});
            if (fail_m == 3) fail_m = 0;
            return;
        end
        fail_m = 0;
        check("dep_pin_busy", {31'd0, bus.busy}, 32'd1);
        occ_m[exp_lk] = 1'b1;
        pin_m[exp_lk] = pin;
        oh = 8'h01 << exp_lk;
        sb.push_back(mk_ev(EV_OPEN, oh, occ_m, 1'b1, exp_lk, 1'b0, 16));
        bus.pin_in = pin; bus.pin_valid = 1'b1;
        tick();
        bus.pin_valid = 1'b0;
        wait_idle();
    endtask

    task automatic do_ret(input logic [2:0] lk, input logic [3:0] pin, input int len);
        logic       hit;
        logic [7:0] oh;
        bus.ret_req = 1'b1; bus.ret_locker = lk;
        tick();
        bus.ret_req = 1'b0;
        if (!occ_m[lk]) begin
            check("ret_free_ignored", {31'd0, bus.busy}, 32'd0);
            return;
        end
        check("ret_busy", {31'd0, bus.busy}, 32'd1);
        hit = (pin == pin_m[lk]);
        if (hit) begin
            occ_m[lk] = 1'b0;
            fail_m    = 0;
            oh        = 8'h01 << lk;
            sb.push_back(mk_ev(EV_OPEN, oh, occ_m, 1'b0, lk, 1'b0, len));
        end else begin
            fail_m++;
            sb.push_back(mk_ev(EV_FAIL, 8'h00, occ_m, 1'b0, 3'd0, fail_m == 3, 0));
        end
        bus.pin_in = pin; bus.pin_valid = 1'b1;
        tick();
        bus.pin_valid = 1'b0;
        if (!hit) begin
            check("ret_fail_locked", {31'd0, bus.locked_out}, {31'd0, fail_m == 3});
            if (fail_m == 3) fail_m = 0;
        end
    endtask

    // Output-event monitor: every door rise, auth_fail or dep_reject pops one expectation.
    ev_t        cur;
    ev_e        act;
    logic [7:0] prev_doors = '0;
    int         run_len    = 0;
    int         exp_len    = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_doors = '0;
            run_len    = 0;
        end else begin
            act = EV_NONE;
            if (bus.locker_doors != 8'h00 && prev_doors == 8'h00) act = EV_OPEN;
            else if (bus.auth_fail)                              act = EV_FAIL;
            else if (bus.dep_reject)                             act = EV_REJECT;
            if (act == EV_NONE && bus.assign_valid)
                check("assign_valid_without_door", 32'd1, 32'd0);
            if (act != EV_NONE) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", int'(act), int'(EV_NONE));
                end else begin
                    cur = sb.pop_front();
                    check("event_kind", int'(act), int'(cur.kind));
                    check("event_occupied", {24'd0, bus.occupied}, {24'd0, cur.occ});
                    if (cur.kind == EV_OPEN) begin
                        exp_len = cur.len;
                        check("open_doors", {24'd0, bus.locker_doors}, {24'd0, cur.doors});
                        check("open_assign_valid", {31'd0, bus.assign_valid}, {31'd0, cur.av});
                        if (cur.av)
                            check("open_assigned_locker", {29'd0, bus.assigned_locker}, {29'd0, cur.locker});
                    end else if (cur.kind == EV_FAIL) begin
                        check("fail_locked_out", {31'd0, bus.locked_out}, {31'd0, cur.locked});
                    end else begin
                        check("reject_full", {31'd0, bus.full}, 32'd1);
                        check("reject_busy_low", {31'd0, bus.busy}, 32'd0);
                    end
                end
            end
            if (bus.locker_doors != 8'h00) begin
                run_len++;
            end else if (prev_doors != 8'h00) begin
                check("door_open_len", run_len, exp_len);
                run_len = 0;
            end
            prev_doors = bus.locker_doors;
        end
    end

    initial begin
        bus.reset_lockers = 1'b0; bus.dep_req = 1'b0; bus.package_present = 1'b0;
        bus.ret_req = 1'b0; bus.ret_locker = '0; bus.pin_in = '0;
        bus.pin_valid = 1'b0; bus.auth_ok = 1'b0;

        //            op      locker pin    auth  exp_locker
        vecs[0]  = '{OP_DEP, 3'd0, 4'hA, 1'b1, 3'd0};
        vecs[1]  = '{OP_DEP, 3'd0, 4'h1, 1'b1, 3'd1};
        vecs[2]  = '{OP_DEP, 3'd0, 4'h2, 1'b1, 3'd2};
        vecs[3]  = '{OP_DEP, 3'd0, 4'h5, 1'b1, 3'd3};
        vecs[4]  = '{OP_DEP, 3'd0, 4'h7, 1'b1, 3'd4};
        vecs[5]  = '{OP_DEP, 3'd0, 4'h9, 1'b1, 3'd5};
        vecs[6]  = '{OP_DEP, 3'd0, 4'hC, 1'b1, 3'd6};
        vecs[7]  = '{OP_DEP, 3'd0, 4'hE, 1'b1, 3'd7};
        vecs[8]  = '{OP_DEP, 3'd0, 4'h0, 1'b1, 3'd0};  // bank full: reject
        vecs[9]  = '{OP_RET, 3'd3, 4'h5, 1'b0, 3'd0};
        vecs[10] = '{OP_DEP, 3'd0, 4'hB, 1'b1, 3'd3};  // reuses freed locker 3
        vecs[11] = '{OP_RET, 3'd0, 4'hA, 1'b0, 3'd0};
        vecs[12] = '{OP_RET, 3'd0, 4'hA, 1'b0, 3'd0};  // locker 0 now free: ignored
        vecs[13] = '{OP_RET, 3'd1, 4'h0, 1'b0, 3'd0};  // wrong PIN, count 1
        vecs[14] = '{OP_DEP, 3'd0, 4'h3, 1'b0, 3'd0};  // courier auth fail, count 2
        vecs[15] = '{OP_RET, 3'd1, 4'h1, 1'b0, 3'd0};  // success clears count
        vecs[16] = '{OP_DEP, 3'd0, 4'h6, 1'b1, 3'd0};

        repeat (3) tick();
        check("rst_doors",        {24'd0, bus.locker_doors},    32'd0);
        check("rst_assigned",     {29'd0, bus.assigned_locker}, 32'd0);
        check("rst_assign_valid", {31'd0, bus.assign_valid},    32'd0);
        check("rst_occupied",     {24'd0, bus.occupied},        32'd0);
        check("rst_full",         {31'd0, bus.full},            32'd0);
        check("rst_busy",         {31'd0, bus.busy},            32'd0);
        check("rst_dep_reject",   {31'd0, bus.dep_reject},      32'd0);
        check("rst_auth_fail",    {31'd0, bus.auth_fail},       32'd0);
        check("rst_locked_out",   {31'd0, bus.locked_out},      32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            if (vecs[i].op == OP_DEP) begin
                do_dep(vecs[i].pin, vecs[i].auth_ok, vecs[i].exp_locker);
            end else begin
                do_ret(vecs[i].locker, vecs[i].pin, 16);
                wait_idle();
            end
        end

        // Same-cycle deposit and retrieval: deposit to locker 1 wins.
        bus.dep_req = 1'b1; bus.package_present = 1'b1;
        bus.ret_req = 1'b1; bus.ret_locker = 3'd2;
        tick();
        bus.dep_req = 1'b0; bus.package_present = 1'b0; bus.ret_req = 1'b0;
        check("dual_busy", {31'd0, bus.busy}, 32'd1);
        check("dual_assigned", {29'd0, bus.assigned_locker}, 32'd1);
        bus.auth_ok = 1'b1; bus.pin_valid = 1'b1;
        tick();
        bus.auth_ok = 1'b0; bus.pin_valid = 1'b0;
        occ_m[1] = 1'b1;
        pin_m[1] = 4'h4;
        sb.push_back(mk_ev(EV_OPEN, 8'h02, occ_m, 1'b1, 3'd1, 1'b0, 16));
        bus.pin_in = 4'h4; bus.pin_valid = 1'b1;
        tick();
        bus.pin_valid = 1'b0;
        wait_idle();
        check("dual_ret_dropped", {31'd0, bus.occupied[2]}, 32'd1);
        check("full_after_fill", {31'd0, bus.full}, 32'd1);

        // Auth timeout: 255 idle cycles in RET_AUTH, no auth_fail.
        bus.ret_req = 1'b1; bus.ret_locker = 3'd2;
        tick();
        bus.ret_req = 1'b0;
        check("timeout_enter", {31'd0, bus.busy}, 32'd1);
        repeat (254) tick();
        check("timeout_last_wait", {31'd0, bus.busy}, 32'd1);
        tick();
        check("timeout_idle", {31'd0, bus.busy}, 32'd0);

        // Three wrong PINs across sessions -> lockout of 64 cycles.
        do_ret(3'd2, 4'h0, 16); wait_idle();
        do_ret(3'd2, 4'hF, 16); wait_idle();
        do_ret(3'd2, 4'h3, 16);
        bus.dep_req = 1'b1; bus.package_present = 1'b1;
        bus.ret_req = 1'b1; bus.ret_locker = 3'd2;
        tick();
        bus.dep_req = 1'b0; bus.package_present = 1'b0; bus.ret_req = 1'b0;
        check("lockout_ignores_req", {31'd0, bus.locked_out}, 32'd1);
        repeat (62) tick();
        check("lockout_last_cycle", {31'd0, bus.locked_out}, 32'd1);
        tick();
        check("lockout_done", {31'd0, bus.locked_out}, 32'd0);
        check("lockout_done_busy", {31'd0, bus.busy}, 32'd0);
        do_ret(3'd2, 4'h9, 16); wait_idle();   // counter restarted: no lockout
        do_ret(3'd2, 4'h2, 16); wait_idle();

        // reset_lockers mid-OPEN: door lasts 5 cycles, bank emptied.
        do_ret(3'd4, 4'h7, 5);
        repeat (4) tick();
        bus.reset_lockers = 1'b1;
        tick();
        bus.reset_lockers = 1'b0;
        occ_m = '0;
        check("rl_doors", {24'd0, bus.locker_doors}, 32'd0);
        check("rl_occupied", {24'd0, bus.occupied}, 32'd0);
        check("rl_busy", {31'd0, bus.busy}, 32'd0);

        // Lockout survives reset_lockers; synchronous reset ends it.
        do_dep(4'h8, 1'b1, 3'd0);
        do_ret(3'd0, 4'h1, 16); wait_idle();
        do_ret(3'd0, 4'h2, 16); wait_idle();
        do_ret(3'd0, 4'h3, 16);
        repeat (3) tick();
        bus.reset_lockers = 1'b1;
        tick();
        bus.reset_lockers = 1'b0;
        occ_m = '0;
        check("rl_lockout_kept", {31'd0, bus.locked_out}, 32'd1);
        check("rl_lockout_occ", {24'd0, bus.occupied}, 32'd0);
        reset = 1'b1;
        tick();
        check("reset_mid_lockout", {31'd0, bus.locked_out}, 32'd0);
        check("reset_mid_lockout_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        fail_m = 0;
        tick();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
